// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one 512x8 single-port SRAM macro between NUM_REQ requesters.
// Optional power-up clear of the whole array: define SRAM_ARB_INIT_CLEAR_EN.
module sram_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int AW      = 9,
   parameter int DW      = 8
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic [NUM_REQ-1:0]            req_valid_i,
   output logic [NUM_REQ-1:0]            req_ready_o,
   input  logic [NUM_REQ-1:0]            req_we_i,
   input  logic [NUM_REQ-1:0][AW-1:0]    req_addr_i,
   input  logic [NUM_REQ-1:0][DW-1:0]    req_wdata_i,
   input  logic [NUM_REQ-1:0][DW-1:0]    req_wmask_i,
   output logic [NUM_REQ-1:0]            rsp_valid_o,
   output logic [DW-1:0]                 rsp_rdata_o,
   output logic                          sram_cen_o,
   output logic                          sram_gwen_o,
   output logic [DW-1:0]                 sram_wen_o,
   output logic [AW-1:0]                 sram_a_o,
   output logic [DW-1:0]                 sram_d_o,
   input  logic [DW-1:0]                 sram_q_i,
   output logic                          busy_o
);

   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef struct packed {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] wmask;
   } req_t;

   typedef struct packed {
      logic          pend;
      logic [PW-1:0] id;
      logic          we;
   } rsp_t;

   logic          in_init;
   logic [AW-1:0] init_a;

`ifdef SRAM_ARB_INIT_CLEAR_EN
   localparam int DEPTH = 2 ** AW;

   typedef enum logic {ST_INIT, ST_IDLE} state_e;

   state_e        state_q, state_d;
   logic [AW-1:0] init_cnt_q, init_cnt_d;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q    <= ST_INIT;
         init_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         init_cnt_q <= init_cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      init_cnt_d = init_cnt_q;
      if (state_q == ST_INIT) begin
         init_cnt_d = init_cnt_q + 1'b1;
         if (init_cnt_q == AW'(DEPTH - 1)) state_d = ST_IDLE;
      end
   end

   assign in_init = (state_q == ST_INIT);
   assign init_a  = init_cnt_q;
`else
   assign in_init = 1'b0;
   assign init_a  = '0;
`endif

   logic [PW-1:0] rr_ptr_q, rr_ptr_d;
   logic [PW-1:0] gnt_idx;
   logic          gnt_vld;
   logic          gnt;
   req_t          win;
   rsp_t          rsp_q, rsp_d;

   logic          cen_d;
   logic          gwen_q, gwen_d;
   logic [DW-1:0] wen_q, wen_d;
   logic [AW-1:0] a_q, a_d;
   logic [DW-1:0] d_q, d_d;

   // First valid requester at or after rr_ptr, wrapping.
   always_comb begin
      int idx;
      gnt_vld = 1'b0;
      gnt_idx = '0;
      idx     = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (int'(rr_ptr_q) + k) % NUM_REQ;
         if (!gnt_vld && req_valid_i[idx]) begin
            gnt_vld = 1'b1;
            gnt_idx = PW'(idx);
         end
      end
   end

   assign gnt = rst_ni && !in_init && gnt_vld;

   always_comb begin
      win.we    = req_we_i[gnt_idx];
      win.addr  = req_addr_i[gnt_idx];
      win.wdata = req_wdata_i[gnt_idx];
      win.wmask = req_wmask_i[gnt_idx];
   end

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) req_ready_o[i] = gnt && (gnt_idx == PW'(i));
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (gnt) rr_ptr_d = (gnt_idx == PW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
   end

   // Macro pins follow the winner on a handshake, otherwise hold their last values.
   always_comb begin
      cen_d  = 1'b1;
      a_d    = a_q;
      gwen_d = gwen_q;
      wen_d  = wen_q;
      d_d    = d_q;
      if (in_init) begin
         cen_d  = 1'b0;
         a_d    = init_a;
         gwen_d = 1'b0;
         wen_d  = '0;
         d_d    = '0;
      end else if (gnt) begin
         cen_d  = 1'b0;
         a_d    = win.addr;
         gwen_d = ~win.we;
         wen_d  = win.we ? ~win.wmask : '1;
         d_d    = win.wdata;
      end
      if (!rst_ni) begin
         cen_d  = 1'b1;
         a_d    = '0;
         gwen_d = 1'b1;
         wen_d  = '1;
         d_d    = '0;
      end
   end

   always_comb begin
      rsp_d      = rsp_q;
      rsp_d.pend = gnt;
      if (gnt) begin
         rsp_d.id = gnt_idx;
         rsp_d.we = win.we;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         rr_ptr_q <= '0;
         rsp_q    <= '0;
         a_q      <= '0;
         gwen_q   <= 1'b1;
         wen_q    <= '1;
         d_q      <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         rsp_q    <= rsp_d;
         a_q      <= a_d;
         gwen_q   <= gwen_d;
         wen_q    <= wen_d;
         d_q      <= d_d;
      end
   end

   assign sram_cen_o  = cen_d;
   assign sram_a_o    = a_d;
   assign sram_gwen_o = gwen_d;
   assign sram_wen_o  = wen_d;
   assign sram_d_o    = d_d;

   // Gated by rst_ni so a response in flight when reset arrives is never seen.
   always_comb begin
      for (int i = 0; i < NUM_REQ; i++)
         rsp_valid_o[i] = rst_ni && rsp_q.pend && (rsp_q.id == PW'(i));
   end

   assign rsp_rdata_o = (rst_ni && rsp_q.pend && !rsp_q.we) ? sram_q_i : '0;
   assign busy_o      = rst_ni && (rsp_q.pend || in_init);

endmodule
